// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - per-frame start/done sequencer for update units
// Launches each client in order on a refresh_clock rising edge, counts frames, overruns and hangs.
module frame_update_scheduler #(
    parameter int NUM_CLIENTS    = 3,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FRAME_W        = 16
) (
    input  logic                   clk_50,
    input  logic                   reset,
    input  logic                   refresh_clock,
    input  logic                   enable,
    output logic [NUM_CLIENTS-1:0] start,
    input  logic [NUM_CLIENTS-1:0] done,
    output logic                   busy,
    output logic [((NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1)-1:0] active_client,
    output logic [FRAME_W-1:0]     frame_count,
    output logic [7:0]             overrun_count,
    output logic                   timeout_flag,
    output logic [((NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1)-1:0] timeout_client
);
    localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]          LAST_CLIENT = CW'(NUM_CLIENTS - 1);
    localparam logic [WW-1:0]          WAIT_MAX    = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_CLIENTS-1:0] ONE_HOT0    = NUM_CLIENTS'(1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t               state;
    logic                 prev_refresh;
    logic [WW-1:0]        wait_count;
    logic                 tick;
    logic                 done_active;
    logic [(2**CW)-1:0]   done_pad;

    // Padding keeps the variable bit-select in range when NUM_CLIENTS is not a power of two.
    assign done_pad    = (2**CW)'(done);
    assign done_active = done_pad[active_client];
    assign tick        = refresh_clock & ~prev_refresh;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state          <= IDLE;
            prev_refresh   <= 1'b1;
            wait_count     <= '0;
            start          <= '0;
            busy           <= 1'b0;
            active_client  <= '0;
            frame_count    <= '0;
            overrun_count  <= '0;
            timeout_flag   <= 1'b0;
            timeout_client <= '0;
        end else begin
            prev_refresh <= refresh_clock;

            case (state)
                IDLE: begin
                    start <= '0;
                    if (tick && enable) begin
                        state         <= LAUNCH;
                        active_client <= '0;
                        start         <= ONE_HOT0;
                        busy          <= 1'b1;
                        frame_count   <= frame_count + 1'b1;
                    end
                end
                LAUNCH: begin
                    start      <= '0;
                    wait_count <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    wait_count <= wait_count + 1'b1;
                    // A hung client is skipped exactly as though it had completed.
                    if (done_active || (wait_count == WAIT_MAX)) begin
                        if (!done_active && !timeout_flag) begin
                            timeout_flag   <= 1'b1;
                            timeout_client <= active_client;
                        end
                        if (active_client == LAST_CLIENT) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            active_client <= '0;
                        end else begin
                            state         <= LAUNCH;
                            active_client <= active_client + 1'b1;
                            start         <= ONE_HOT0 << (active_client + 1'b1);
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    start         <= '0;
                    busy          <= 1'b0;
                    active_client <= '0;
                end
            endcase

            if (tick && (state != IDLE) && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb/tb_frame_update_scheduler.sv - scoreboard bench for frame_update_scheduler
// Frame-level model predicts start pulses and busy falls; a monitor pops and compares them.
module tb_frame_update_scheduler;
    localparam int NC = 3;
    localparam int TO = 16;
    localparam int FW = 4;

    logic          clk_50;
    logic          reset;
    logic          refresh_clock;
    logic          enable;
    logic [NC-1:0] start;
    logic [NC-1:0] done;
    logic          busy;
    logic [1:0]    active_client;
    logic [FW-1:0] frame_count;
    logic [7:0]    overrun_count;
    logic          timeout_flag;
    logic [1:0]    timeout_client;

    frame_update_scheduler #(.NUM_CLIENTS(NC), .TIMEOUT_CYCLES(TO), .FRAME_W(FW)) dut (
        .clk_50(clk_50), .reset(reset), .refresh_clock(refresh_clock), .enable(enable),
        .start(start), .done(done), .busy(busy), .active_client(active_client),
        .frame_count(frame_count), .overrun_count(overrun_count),
        .timeout_flag(timeout_flag), .timeout_client(timeout_client)
    );

    typedef struct {
        int          c;
        logic [2:0]  v;
        int          idx;
    } exp_t;

    exp_t exp_start[$];
    int   exp_end[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int plan[NC];
    int plan_cfg[NC];
    int due[NC];
    int mode = 0;
    int m_frame = 0;
    int m_over = 0;
    int m_tflag = 0;
    int m_tclient = 0;
    int model_end = -1;
    logic model_prev = 1'b1;
    bit mon_on = 0;
    bit abort = 0;
    logic prev_busy;

    initial begin
        clk_50 = 1'b0;
        forever #10 clk_50 = ~clk_50;
    end

    always @(posedge clk_50) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return TO;
        if (r == 2) return TO + 1;
        return $urandom_range(1, 8);
    endfunction

    // Frame-level reference: start times follow from tick time and each client's response delay.
    task automatic model_tick(input int c);
        int s;
        int e;
        int d;
        bit to;
        if (c <= model_end) begin
            if (m_over < 255) m_over++;
        end else if (enable) begin
            m_frame = (m_frame + 1) % (1 << FW);
            s = c + 1;
            for (int i = 0; i < NC; i++) begin
                d = (mode == 0) ? pick_delay() : plan_cfg[i];
                plan[i] = d;
                to = (d == 0) || (d > TO);
                e = s + (to ? TO : d);
                if (to && m_tflag == 0) begin
                    m_tflag = 1;
                    m_tclient = i;
                end
                exp_start.push_back(exp_t'{c: s, v: 3'(1 << i), idx: i});
                model_end = e;
                s = e + 1;
            end
            exp_end.push_back(model_end + 1);
        end
    endtask

    task automatic step(input logic r);
        @(posedge clk_50);
        #1;
        refresh_clock = r;
        if (r && !model_prev) model_tick(cyc);
        model_prev = r;
    endtask

    task automatic wait_idle();
        while (cyc <= model_end + 1) step(1'b0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'(m_frame));
        chk({tag, "_overrun_count"}, 32'(overrun_count), 32'(m_over));
        chk({tag, "_timeout_flag"}, 32'(timeout_flag), 32'(m_tflag));
        chk({tag, "_timeout_client"}, 32'(timeout_client), 32'(m_tclient));
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    // Responders: pulse done[i] a planned number of cycles after start[i]; 0 means never.
    initial begin
        done = '0;
        for (int i = 0; i < NC; i++) due[i] = -1;
        forever begin
            @(posedge clk_50);
            #1;
            for (int i = 0; i < NC; i++) done[i] = (due[i] == cyc);
        end
    end

    // Monitor: pops expectations whenever the DUT presents a start pulse or busy falls.
    initial begin
        exp_t e;
        int   ec;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk_50);
            if (mon_on) begin
                while (exp_start.size() > 0 && exp_start[0].c < cyc) begin
                    e = exp_start.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL start_missing: expected start %b at cycle %0d, still absent at cycle %0d", e.v, e.c, cyc);
                end
                while (exp_end.size() > 0 && exp_end[0] < cyc) begin
                    ec = exp_end.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL busy_fall_missing: expected at cycle %0d, still absent at cycle %0d", ec, cyc);
                end
                if (start !== 3'b000) begin
                    for (int i = 0; i < NC; i++)
                        if (start[i] === 1'b1) due[i] = (plan[i] == 0) ? -1 : cyc + plan[i];
                    checks++;
                    if (exp_start.size() == 0) begin
                        errors++;
                        $display("FAIL start_unexpected: got start %b at cycle %0d, required none", start, cyc);
                    end else begin
                        e = exp_start.pop_front();
                        if (e.c != cyc || e.v !== start || active_client !== 2'(e.idx)) begin
                            errors++;
                            $display("FAIL start_pulse: got %b client %0d at cycle %0d, required %b client %0d at cycle %0d",
                                     start, active_client, cyc, e.v, e.idx, e.c);
                        end
                    end
                end
                if (prev_busy === 1'b1 && busy === 1'b0 && !abort) begin
                    checks++;
                    if (exp_end.size() == 0) begin
                        errors++;
                        $display("FAIL busy_fall_unexpected: got fall at cycle %0d, required none", cyc);
                    end else begin
                        ec = exp_end.pop_front();
                        if (ec != cyc) begin
                            errors++;
                            $display("FAIL busy_fall: got cycle %0d required cycle %0d", cyc, ec);
                        end
                    end
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        refresh_clock = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < NC; i++) begin
            plan[i] = 0;
            plan_cfg[i] = 0;
        end

        // Reset with refresh_clock high: release must not look like a tick.
        repeat (10) begin
            @(posedge clk_50);
            #1;
        end
        reset = 1'b0;
        model_prev = 1'b1;
        mon_on = 1;
        repeat (3) step(1'b1);
        chk("reset_start", 32'(start), 32'd0);
        chk("reset_active_client", 32'(active_client), 32'd0);
        check_status("reset");

        // Five-cycle responders.
        mode = 1;
        plan_cfg = '{5, 5, 5};
        step(1'b0);
        step(1'b1);
        wait_idle();
        check_status("basic");

        // Ten-cycle responders with a second edge while busy, then a fresh frame.
        plan_cfg = '{10, 10, 10};
        step(1'b0);
        step(1'b1);
        repeat (5) step(1'b0);
        step(1'b1);
        wait_idle();
        check_status("overrun_once");
        step(1'b1);
        wait_idle();
        check_status("after_overrun");

        // Edge on the last-done cycle is an overrun; edge one cycle later starts a frame.
        plan_cfg = '{3, 3, 3};
        step(1'b0);
        step(1'b1);
        while (cyc < model_end - 1) step(1'b0);
        step(1'b1);
        while (cyc < model_end + 1) step(1'b0);
        step(1'b1);
        wait_idle();
        check_status("boundary");

        // Client 1 hangs; later client 0 hangs without changing the latched index.
        plan_cfg = '{5, 0, 5};
        step(1'b0);
        step(1'b1);
        wait_idle();
        check_status("timeout1");
        plan_cfg = '{0, 2, 2};
        step(1'b0);
        step(1'b1);
        wait_idle();
        check_status("timeout0");

        // enable low at an idle tick, then dropped mid-frame.
        enable = 1'b0;
        step(1'b0);
        step(1'b1);
        repeat (4) step(1'b0);
        check_status("disabled_tick");
        enable = 1'b1;
        plan_cfg = '{4, 4, 4};
        step(1'b1);
        repeat (3) step(1'b0);
        enable = 1'b0;
        wait_idle();
        step(1'b1);
        repeat (3) step(1'b0);
        check_status("enable_drop");
        enable = 1'b1;

        // Randomised frames with random extra edges.
        mode = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b0);
            step(1'b1);
            n = $urandom_range(0, 30);
            for (int j = 0; j < n; j++) step(logic'($urandom_range(0, 3) == 0));
            wait_idle();
            check_status("random");
        end

        // Hung clients and a fast refresh drive overrun_count into saturation.
        mode = 1;
        plan_cfg = '{0, 0, 0};
        for (int k = 0; k < 12; k++) begin
            step(1'b0);
            step(1'b1);
            for (int j = 0; j < 25; j++) begin
                step(1'b0);
                step(1'b1);
            end
            wait_idle();
        end
        check_status("saturate");

        // Reset while waiting on client 0.
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        @(posedge clk_50);
        #1;
        reset = 1'b1;
        abort = 1;
        exp_start.delete();
        exp_end.delete();
        for (int i = 0; i < NC; i++) due[i] = -1;
        @(posedge clk_50);
        #1;
        chk("midreset_start", 32'(start), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_active_client", 32'(active_client), 32'd0);
        chk("midreset_frame_count", 32'(frame_count), 32'd0);
        chk("midreset_overrun_count", 32'(overrun_count), 32'd0);
        chk("midreset_timeout_flag", 32'(timeout_flag), 32'd0);
        chk("midreset_timeout_client", 32'(timeout_client), 32'd0);
        reset = 1'b0;
        m_frame = 0;
        m_over = 0;
        m_tflag = 0;
        m_tclient = 0;
        model_end = -1;
        model_prev = refresh_clock;
        repeat (20) step(1'b0);
        abort = 0;

        plan_cfg = '{2, 2, 2};
        step(1'b1);
        wait_idle();
        check_status("recover");

        repeat (3) step(1'b0);
        chk("exp_start_drained", 32'(exp_start.size()), 32'd0);
        chk("exp_end_drained", 32'(exp_end.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
